// File: rtl/audio_pkg.sv
// Shared types and sizing for the audio frame buffer.
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int FRAME_N  = 100;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    FILL,
    ISSUE,
    HOLD,
    STALL
  } state_t;

endpackage

// File: rtl/audio_frame_ram.sv
// Sample store: one write port, one registered read port.
// Out-of-range reads return zero; the array itself is never reset.
module audio_frame_ram
  import audio_pkg::*;
#(
  parameter int W  = SAMPLE_W,
  parameter int BW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [BW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          rd_ok,
  input  logic [BW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int D = 1 << BW;

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata <= '0;
    else        rdata <= rd_ok ? mem[raddr] : '0;
  end

endmodule

// File: rtl/audio_frame_buffer.sv
// Collects N streamed samples into a frame and holds it for the consumer.
// AUDIO_FRAME_DBUF_EN selects ping-pong banks so filling overlaps holding.
module audio_frame_buffer
  import audio_pkg::*;
#(
  parameter int N  = FRAME_N,
  parameter int W  = SAMPLE_W,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          frame_start,
  output logic          frame_busy,
  input  logic          cons_done,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [15:0]   frame_count,
  output logic [15:0]   drop_count
);

`ifdef AUDIO_FRAME_DBUF_EN
  localparam int BW = AW + 1;
`else
  localparam int BW = AW;
`endif

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [15:0]   fcnt_q, dcnt_q;
  logic          accept;
  logic          rd_ok;
  logic [BW-1:0] waddr, raddr;

  assign accept = in_valid && in_ready;
  assign rd_ok  = ({1'b0, rd_addr} < (AW+1)'(N));

`ifdef AUDIO_FRAME_DBUF_EN
  logic wbank_q, wbank_d;
  logic hbank_q, hbank_d;
  logic held_q, held_d;
  logic rel, go_issue;

  assign waddr = {wbank_q, ptr_q};
  assign raddr = {hbank_q, rd_addr};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wbank_d     = wbank_q;
    hbank_d     = hbank_q;
    held_d      = held_q;
    in_ready    = 1'b0;
    frame_start = 1'b0;
    frame_busy  = held_q;
    go_issue    = 1'b0;
    rel = cons_done && held_q && (state_q != ISSUE);
    unique case (state_q)
      FILL:    in_ready = 1'b1;
      ISSUE: begin
        in_ready    = 1'b1;
        frame_start = 1'b1;
        state_d     = FILL;
      end
      default: ;
    endcase
    if (rel) held_d = 1'b0;
    if (accept) begin
      if (ptr_q == LAST) begin
        ptr_d = '0;
        if (held_q && !rel) state_d = STALL;
        else                go_issue = 1'b1;
      end else begin
        ptr_d = ptr_q + AW'(1);
      end
    end
    if (state_q == STALL && rel) go_issue = 1'b1;
    // Issuing hands the full bank to the consumer and flips the fill bank.
    if (go_issue) begin
      state_d = ISSUE;
      held_d  = 1'b1;
      hbank_d = wbank_q;
      wbank_d = ~wbank_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbank_q <= 1'b0;
      hbank_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      hbank_q <= hbank_d;
      held_q  <= held_d;
    end
  end
`else
  assign waddr = ptr_q;
  assign raddr = rd_addr;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    in_ready    = 1'b0;
    frame_start = 1'b0;
    frame_busy  = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (accept) begin
          if (ptr_q == LAST) begin
            ptr_d   = '0;
            state_d = ISSUE;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      ISSUE: begin
        frame_start = 1'b1;
        frame_busy  = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        frame_busy = 1'b1;
        if (cons_done) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      ptr_q   <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (state_q == ISSUE) fcnt_q <= fcnt_q + 16'd1;
      if (in_valid && !in_ready && dcnt_q != 16'hFFFF)
        dcnt_q <= dcnt_q + 16'd1;
    end
  end

  assign frame_count = fcnt_q;
  assign drop_count  = dcnt_q;

  audio_frame_ram #(
    .W  (W),
    .BW (BW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (accept),
    .waddr (waddr),
    .wdata (in_data),
    .rd_ok (rd_ok),
    .raddr (raddr),
    .rdata (rd_data)
  );

endmodule
